// File: rtl/mii_tx_sched.sv
// mii_tx_sched: shares one MII transmit nibble path between N_REQ byte-stream
// frame sources. Round-robin arbitration at frame boundaries, byte-to-nibble
// serialisation (low nibble first), zero padding of short frames, truncation
// of oversize frames and a fixed idle gap after every frame.
module mii_tx_sched #(
  parameter int N_REQ       = 2,
  parameter int MIN_BYTES   = 60,
  parameter int MAX_BYTES   = 1514,
  parameter int IFG_NIBBLES = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [3:0]         txd,
  output logic               txdv,
  output logic [2:0]         grant,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun,
  output logic               oversize
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_PAD, S_DRAIN, S_GAP} state_t;

  localparam logic [10:0] MIN_C = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_C = 11'(MAX_BYTES);
  // The IDLE arbitration cycle is also a txdv=0 cycle, so the GAP state itself
  // lasts IFG_NIBBLES-1 cycles and back-to-back frames see exactly IFG_NIBBLES
  // idle nibbles between them.
  localparam logic [15:0] GAP_END = 16'(IFG_NIBBLES - 2);

  state_t      r_state;
  logic        r_ph;
  logic [2:0]  r_grant;
  logic [2:0]  r_ptr;
  logic [10:0] r_byte_cnt;
  logic [15:0] r_gap_cnt;
  logic [3:0]  r_txd;
  logic        r_txdv;
  logic        r_done;
  logic        r_under;
  logic        r_over;

  logic        w_vld;
  logic        w_last;
  logic [7:0]  w_byte;
  logic        w_any;
  logic [2:0]  w_pick;
  logic        w_rdy_on;
  logic [10:0] w_cnt_nxt;

  // Select the granted requester's valid/last/data
  always_comb begin
    w_vld  = 1'b0;
    w_last = 1'b0;
    w_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == 3'(i)) begin
        w_vld  = req_valid[i];
        w_last = req_last[i];
        w_byte = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin pick: first valid requester after the pointer, cyclically
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_any && req_valid[i] && (i == (int'(r_ptr) + k) % N_REQ)) begin
          w_any  = 1'b1;
          w_pick = 3'(i);
        end
      end
    end
  end

  assign w_rdy_on  = ((r_state == S_SEND) && r_ph) || (r_state == S_DRAIN);
  assign w_cnt_nxt = r_byte_cnt + 11'd1;

  // Ready is one-hot on the granted requester while a byte can be consumed
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = w_rdy_on && (r_grant == 3'(i));
    end
  end

  // Frame scheduler FSM with registered nibble and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ph       <= 1'b0;
      r_grant    <= 3'd0;
      r_ptr      <= 3'(N_REQ - 1);
      r_byte_cnt <= 11'd0;
      r_gap_cnt  <= 16'd0;
      r_txd      <= 4'h0;
      r_txdv     <= 1'b0;
      r_done     <= 1'b0;
      r_under    <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_under   <= 1'b0;
      r_over    <= 1'b0;
      r_gap_cnt <= 16'd0;
      case (r_state)
        S_IDLE: begin
          r_txd  <= 4'h0;
          r_txdv <= 1'b0;
          if (w_any) begin
            r_grant    <= w_pick;
            r_ptr      <= w_pick;
            r_byte_cnt <= 11'd0;
            r_ph       <= 1'b0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (!r_ph) begin
            if (w_vld) begin
              r_txd  <= w_byte[3:0];
              r_txdv <= 1'b1;
              r_ph   <= 1'b1;
            end else begin
              // Source starved: abandon the frame and swallow its remainder
              r_txd   <= 4'h0;
              r_txdv  <= 1'b0;
              r_under <= 1'b1;
              r_state <= S_DRAIN;
            end
          end else begin
            r_txd      <= w_byte[7:4];
            r_txdv     <= 1'b1;
            r_ph       <= 1'b0;
            r_byte_cnt <= w_cnt_nxt;
            if (w_last) begin
              if (w_cnt_nxt < MIN_C) begin
                r_state <= S_PAD;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_GAP;
              end
            end else if (w_cnt_nxt == MAX_C) begin
              r_over  <= 1'b1;
              r_state <= S_DRAIN;
            end
          end
        end
        S_PAD: begin
          r_txd  <= 4'h0;
          r_txdv <= 1'b1;
          r_ph   <= ~r_ph;
          if (r_ph) begin
            r_byte_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == MIN_C) begin
              r_done  <= 1'b1;
              r_state <= S_GAP;
            end
          end
        end
        S_DRAIN: begin
          r_txd  <= 4'h0;
          r_txdv <= 1'b0;
          if (w_vld && w_last) begin
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_txd  <= 4'h0;
          r_txdv <= 1'b0;
          if (r_gap_cnt == GAP_END) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign txd        = r_txd;
  assign txdv       = r_txdv;
  assign grant      = r_grant;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;
  assign underrun   = r_under;
  assign oversize   = r_over;

endmodule

// File: tb/tb_mii_tx_sched.sv
// Self-checking bench for mii_tx_sched: byte-queue sources, a negedge output
// monitor and a frame-level reference model of the expected nibble stream.
module tb_mii_tx_sched;
  localparam int N    = 2;
  localparam int MINB = 60;
  localparam int MAXB = 1514;
  localparam int IFG  = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [3:0]     txd;
  logic           txdv;
  logic [2:0]     grant;
  logic           busy, frame_done, underrun, oversize;

  always #5 clk = ~clk;

  mii_tx_sched #(.N_REQ(N), .MIN_BYTES(MINB), .MAX_BYTES(MAXB), .IFG_NIBBLES(IFG)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .txd(txd), .txdv(txdv), .grant(grant), .busy(busy),
    .frame_done(frame_done), .underrun(underrun), .oversize(oversize));

  int checks = 0;
  int errors = 0;

  // Sources
  logic [7:0] q_d0[$], q_d1[$];
  bit         q_l0[$], q_l1[$];
  bit         hs[N];
  int         acc_cnt[N];
  int         stall_at[N];
  int         stall_left[N];

  // Monitor
  logic [3:0] cap_nib[$];
  int         fr_len[$], fr_gnt[$], fr_gap[$];
  int         n_done, n_under, n_over, n_rr;
  int         low_run, cur_len;
  bit         prev_dv;
  int         cyc, first_vld, first_tx;

  // Model
  logic [3:0] exp_nib[$];
  int         e_done, e_under, e_over;

  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N; i++) begin
      hs[i] = 1'b0; acc_cnt[i] = 0; stall_at[i] = -1; stall_left[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (hs[0] && q_d0.size() > 0) begin
        void'(q_d0.pop_front()); void'(q_l0.pop_front()); acc_cnt[0]++;
      end
      if (hs[1] && q_d1.size() > 0) begin
        void'(q_d1.pop_front()); void'(q_l1.pop_front()); acc_cnt[1]++;
      end
      if (stall_left[0] > 0 && acc_cnt[0] == stall_at[0]) begin
        req_valid[0] = 1'b0; stall_left[0]--;
      end else begin
        req_valid[0]   = (q_d0.size() > 0);
        req_data[7:0]  = (q_d0.size() > 0) ? q_d0[0] : 8'h00;
        req_last[0]    = (q_d0.size() > 0) ? q_l0[0] : 1'b0;
      end
      if (stall_left[1] > 0 && acc_cnt[1] == stall_at[1]) begin
        req_valid[1] = 1'b0; stall_left[1]--;
      end else begin
        req_valid[1]   = (q_d1.size() > 0);
        req_data[15:8] = (q_d1.size() > 0) ? q_d1[0] : 8'h00;
        req_last[1]    = (q_d1.size() > 0) ? q_l1[0] : 1'b0;
      end
      hs[0] = req_valid[0] && req_ready[0];
      hs[1] = req_valid[1] && req_ready[1];
    end
  end

  initial begin
    cyc = 0; first_vld = -1;
    forever begin
      @(posedge clk);
      cyc++;
      if (req_valid != '0 && first_vld < 0) first_vld = cyc;
    end
  end

  initial begin
    prev_dv = 1'b0; low_run = 0; cur_len = 0; first_tx = -1;
    n_done = 0; n_under = 0; n_over = 0; n_rr = 0;
    forever begin
      @(negedge clk);
      if (txdv) begin
        if (!prev_dv) begin
          fr_gnt.push_back(int'(grant)); fr_gap.push_back(low_run); cur_len = 0;
        end
        if (first_tx < 0) first_tx = cyc;
        cap_nib.push_back(txd);
        cur_len++;
        low_run = 0;
      end else begin
        if (prev_dv) fr_len.push_back(cur_len);
        low_run++;
      end
      prev_dv = txdv;
      if (frame_done) n_done++;
      if (underrun)   n_under++;
      if (oversize)   n_over++;
      if ($countones(req_ready) > 1) n_rr++;
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    cap_nib.delete(); fr_len.delete(); fr_gnt.delete(); fr_gap.delete(); exp_nib.delete();
    n_done = 0; n_under = 0; n_over = 0; low_run = 0;
    e_done = 0; e_under = 0; e_over = 0;
    first_vld = -1; first_tx = -1;
  endtask

  // Expected output of one frame: bytes sent (cut at the stall point or at
  // MAXB), then zero pad up to MINB bytes if the frame ended normally.
  task automatic model(input logic [7:0] d[$], input int stall);
    bit under, over;
    int n;
    under = (stall >= 0) && (stall < d.size());
    over  = !under && (d.size() > MAXB);
    n     = under ? stall : (over ? MAXB : d.size());
    for (int b = 0; b < n; b++) begin
      exp_nib.push_back(d[b][3:0]);
      exp_nib.push_back(d[b][7:4]);
    end
    if (!under && !over)
      for (int b = n; b < MINB; b++) begin exp_nib.push_back(4'h0); exp_nib.push_back(4'h0); end
    if (under) e_under++;
    else if (over) e_over++;
    else e_done++;
  endtask

  // mode 0 random, 1 ramp, 2 constant 0xA5; stall >= 0 drops valid after that many bytes
  task automatic load(input int r, input int len, input int mode, input int stall);
    logic [7:0] d[$];
    for (int b = 0; b < len; b++)
      d.push_back(mode == 1 ? 8'(b) : (mode == 2 ? 8'hA5 : 8'($urandom)));
    for (int b = 0; b < len; b++) begin
      if (r == 0) begin q_d0.push_back(d[b]); q_l0.push_back(b == len - 1); end
      else        begin q_d1.push_back(d[b]); q_l1.push_back(b == len - 1); end
    end
    if (stall >= 0) begin stall_at[r] = acc_cnt[r] + stall; stall_left[r] = 5; end
    model(d, stall);
  endtask

  task automatic wait_done(input int budget, output bit to);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(q_d0.size() == 0 && q_d1.size() == 0 && req_valid == '0 && !busy) && n < budget);
    to = (n >= budget);
    repeat (2) @(negedge clk);
  endtask

  function automatic int first_diff();
    int n;
    n = (cap_nib.size() < exp_nib.size()) ? cap_nib.size() : exp_nib.size();
    for (int k = 0; k < n; k++) if (cap_nib[k] !== exp_nib[k]) return k;
    if (cap_nib.size() != exp_nib.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (txdv !== 1'b0) begin errors++; $display("FAIL rst_txdv: got %b expected 0", txdv); end
    checks++; if (txd !== 4'h0) begin errors++; $display("FAIL rst_txd: got %h expected 0", txd); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if ({frame_done, underrun, oversize} !== 3'b000) begin
      errors++; $display("FAIL rst_pulses: got %b expected 000", {frame_done, underrun, oversize}); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit to; int fd;
    clear_mon();
    load(0, $urandom_range(1, 80), 0, -1);
    load(1, $urandom_range(1, 80), 0, -1);
    load(0, $urandom_range(1, 80), 0, -1);
    load(1, $urandom_range(1, 80), 0, -1);
    wait_done(4000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout: got timeout expected completion"); end
    fd = first_diff();
    checks++; if (fd !== -1) begin errors++;
      $display("FAIL b2b_nibbles: got %0d nibbles (first diff %0d) expected %0d", cap_nib.size(), fd, exp_nib.size()); end
    checks++; if (fr_gnt.size() !== 4) begin errors++; $display("FAIL b2b_frames: got %0d expected 4", fr_gnt.size()); end
    else begin
      for (int f = 0; f < 4; f++) begin
        checks++; if (fr_gnt[f] !== f % 2) begin errors++;
          $display("FAIL b2b_grant%0d: got %0d expected %0d", f, fr_gnt[f], f % 2); end
      end
      for (int f = 1; f < 4; f++) begin
        checks++; if (fr_gap[f] !== IFG) begin errors++;
          $display("FAIL b2b_gap%0d: got %0d idle expected %0d", f, fr_gap[f], IFG); end
      end
    end
    checks++; if (n_done !== e_done) begin errors++; $display("FAIL b2b_done: got %0d expected %0d", n_done, e_done); end
  endtask

  task automatic test_basic();
    bit to; int fd;
    clear_mon();
    load(0, 64, 1, -1);
    wait_done(2000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got timeout expected completion"); end
    fd = first_diff();
    checks++; if (fd !== -1) begin errors++;
      $display("FAIL basic_nibbles: got %0d nibbles (first diff %0d) expected %0d", cap_nib.size(), fd, exp_nib.size()); end
    checks++; if (fr_len.size() !== 1 || fr_len[0] !== 128) begin errors++;
      $display("FAIL basic_contig: got %0d runs expected one run of 128", fr_len.size()); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", n_done); end
    checks++; if (n_under !== 0 || n_over !== 0) begin errors++;
      $display("FAIL basic_errpulse: got under %0d over %0d expected 0 0", n_under, n_over); end
    // edges with req_valid high up to and including the one that launches the first nibble
    checks++; if (first_tx - first_vld + 1 !== 2) begin errors++;
      $display("FAIL basic_latency: got %0d edges expected 2", first_tx - first_vld + 1); end
  endtask

  task automatic test_pad();
    bit to; int fd;
    clear_mon();
    load(1, 10, 2, -1);
    wait_done(2000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL pad_timeout: got timeout expected completion"); end
    fd = first_diff();
    checks++; if (fd !== -1) begin errors++;
      $display("FAIL pad_nibbles: got %0d nibbles (first diff %0d) expected %0d", cap_nib.size(), fd, exp_nib.size()); end
    checks++; if (fr_gnt.size() !== 1 || fr_gnt[0] !== 1) begin errors++;
      $display("FAIL pad_grant: got %0d frames expected one from req1", fr_gnt.size()); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL pad_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_underrun();
    bit to; int fd;
    clear_mon();
    load(0, 40, 0, 19);
    wait_done(2000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL under_timeout: got timeout expected drain to last"); end
    fd = first_diff();
    checks++; if (fd !== -1) begin errors++;
      $display("FAIL under_nibbles: got %0d nibbles (first diff %0d) expected %0d", cap_nib.size(), fd, exp_nib.size()); end
    checks++; if (n_under !== 1) begin errors++; $display("FAIL under_pulse: got %0d expected 1", n_under); end
    checks++; if (n_done !== 0 || n_over !== 0) begin errors++;
      $display("FAIL under_other: got done %0d over %0d expected 0 0", n_done, n_over); end
  endtask

  task automatic test_oversize();
    bit to; int fd;
    for (int t = 0; t < 2; t++) begin
      clear_mon();
      load(0, t == 0 ? 1600 : MAXB, 0, -1);
      wait_done(6000, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL over%0d_timeout: got timeout expected completion", t); end
      fd = first_diff();
      checks++; if (fd !== -1) begin errors++;
        $display("FAIL over%0d_nibbles: got %0d nibbles (first diff %0d) expected %0d", t, cap_nib.size(), fd, exp_nib.size()); end
      checks++; if (n_over !== e_over) begin errors++; $display("FAIL over%0d_pulse: got %0d expected %0d", t, n_over, e_over); end
      checks++; if (n_done !== e_done) begin errors++; $display("FAIL over%0d_done: got %0d expected %0d", t, n_done, e_done); end
    end
  endtask

  task automatic test_random();
    bit to; int fd, r;
    for (int it = 0; it < 8; it++) begin
      clear_mon();
      r = $urandom_range(0, 1);
      load(r, $urandom_range(1, 140), 0, -1);
      wait_done(2000, to);
      fd = first_diff();
      checks++; if (to !== 1'b0 || fd !== -1) begin errors++;
        $display("FAIL rand%0d_nibbles: got %0d nibbles (first diff %0d, timeout %0d) expected %0d",
                 it, cap_nib.size(), fd, to, exp_nib.size()); end
      checks++; if (fr_gnt.size() !== 1 || fr_gnt[0] !== r) begin errors++;
        $display("FAIL rand%0d_grant: got %0d frames expected one from req%0d", it, fr_gnt.size(), r); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL rand%0d_done: got %0d expected 1", it, n_done); end
    end
  endtask

  task automatic test_reset_mid();
    bit to; int n, fd;
    clear_mon();
    load(0, 50, 0, -1);
    n = 0;
    while (!txdv && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++; if (txdv !== 1'b1) begin errors++; $display("FAIL rstmid_sending: got txdv %b expected 1", txdv); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (txdv !== 1'b0) begin errors++; $display("FAIL rstmid_txdv: got %b expected 0", txdv); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(posedge clk);
    q_d0.delete(); q_l0.delete(); q_d1.delete(); q_l1.delete();
    stall_left[0] = 0; stall_left[1] = 0;
    clear_mon();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    load(0, 8, 0, -1);
    load(1, 8, 0, -1);
    wait_done(2000, to);
    fd = first_diff();
    checks++; if (to !== 1'b0 || fd !== -1) begin errors++;
      $display("FAIL rstmid_nibbles: got %0d nibbles (first diff %0d, timeout %0d) expected %0d",
               cap_nib.size(), fd, to, exp_nib.size()); end
    checks++; if (fr_gnt.size() !== 2 || fr_gnt[0] !== 0) begin errors++;
      $display("FAIL rstmid_grant: got %0d frames expected req0 first", fr_gnt.size()); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_basic();
    test_pad();
    test_underrun();
    test_oversize();
    test_random();
    test_reset_mid();
    checks++; if (n_rr !== 0) begin errors++; $display("FAIL ready_onehot: got %0d bad cycles expected 0", n_rr); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
